// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - ID-stage inputs and ID/EX control outputs of pipe_ctrl_unit
interface pipe_ctrl_unit_if #(parameter int ALUOP_W = 4);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic               id_valid;
  logic [4:0]         ex_rt;
  logic               branch_taken;
  logic               stall;
  logic               flush;
  logic               ex_reg_write;
  logic               ex_mem_to_reg;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_branch;
  logic               ex_reg_dst;
  logic               ex_alu_src;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [1:0]         ex_jump;
  logic [2:0]         ex_branch_op;
  logic               ex_valid;
  logic               md_busy;
  logic               md_done;

  modport master (
    output opcode, funct, rs, rt, id_valid, ex_rt, branch_taken,
    input  stall, flush, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_reg_dst, ex_alu_src, ex_alu_op, ex_jump, ex_branch_op,
           ex_valid, md_busy, md_done
  );

  modport slave (
    input  opcode, funct, rs, rt, id_valid, ex_rt, branch_taken,
    output stall, flush, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_reg_dst, ex_alu_src, ex_alu_op, ex_jump, ex_branch_op,
           ex_valid, md_busy, md_done
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - ID decode, ID/EX control register, load-use/flush hazard unit
// Optional multiply/divide sequencer compiled in with PIPE_CTRL_MULDIV_EN.
module pipe_ctrl_unit #(
  parameter int ALUOP_W = 4,
  parameter int MD_LAT  = 32
) (
  input logic            clock,
  input logic            reset,
  pipe_ctrl_unit_if.slave bus
);

  if (ALUOP_W < 4 || MD_LAT < 2) begin : g_bad_param
    $error("pipe_ctrl_unit: ALUOP_W must be >= 4 and MD_LAT >= 2");
  end

  logic       reg_write_d, mem_to_reg_d, mem_read_d, mem_write_d;
  logic       branch_d, reg_dst_d, alu_src_d;
  logic [3:0] alu_op_d;
  logic [1:0] jump_d;
  logic [2:0] branch_op_d;
`ifdef PIPE_CTRL_MULDIV_EN
  logic       md_op_d, md_rd_d;
`endif

  always_comb begin
    reg_write_d = 1'b0; mem_to_reg_d = 1'b0; mem_read_d = 1'b0; mem_write_d = 1'b0;
    branch_d = 1'b0; reg_dst_d = 1'b0; alu_src_d = 1'b0;
    alu_op_d = 4'h0; jump_d = 2'b00; branch_op_d = 3'd0;
`ifdef PIPE_CTRL_MULDIV_EN
    md_op_d = 1'b0; md_rd_d = 1'b0;
`endif
    case (bus.opcode)
      6'h00: begin
        reg_write_d = 1'b1;
        case (bus.funct)
          6'h20: alu_op_d = 4'h1;
          6'h21: alu_op_d = 4'hA;
          6'h22: alu_op_d = 4'h2;
          6'h23: alu_op_d = 4'hB;
          6'h24: alu_op_d = 4'h3;
          6'h25: alu_op_d = 4'h4;
          6'h27: alu_op_d = 4'h5;
          6'h2A: alu_op_d = 4'h6;
          6'h00: alu_op_d = 4'h7;
          6'h02: alu_op_d = 4'h8;
          6'h03: alu_op_d = 4'h9;
          6'h08: begin reg_write_d = 1'b0; jump_d = 2'b01; end
`ifdef PIPE_CTRL_MULDIV_EN
          6'h18, 6'h19, 6'h1A, 6'h1B: begin reg_write_d = 1'b0; md_op_d = 1'b1; end
          6'h10: begin alu_op_d = 4'hC; md_rd_d = 1'b1; end
          6'h12: begin alu_op_d = 4'hD; md_rd_d = 1'b1; end
`endif
          default: reg_write_d = 1'b0;
        endcase
      end
      6'h0C, 6'h0D, 6'h0A, 6'h08, 6'h09, 6'h0F, 6'h23: begin
        reg_write_d = 1'b1; alu_src_d = 1'b1; reg_dst_d = 1'b1;
        case (bus.opcode)
          6'h0C:   alu_op_d = 4'h3;
          6'h0D:   alu_op_d = 4'h4;
          6'h0A:   alu_op_d = 4'h6;
          6'h09:   alu_op_d = 4'hA;
          6'h0F:   alu_op_d = 4'hF;
          default: alu_op_d = 4'h1;
        endcase
        mem_read_d   = (bus.opcode == 6'h23);
        mem_to_reg_d = (bus.opcode == 6'h23);
      end
      6'h2B: begin alu_op_d = 4'h1; alu_src_d = 1'b1; mem_write_d = 1'b1; end
      6'h04: begin branch_d = 1'b1; branch_op_d = 3'd1; end
      6'h05: begin branch_d = 1'b1; branch_op_d = 3'd2; end
      6'h07: begin branch_d = 1'b1; branch_op_d = 3'd3; end
      6'h01: begin branch_d = 1'b1; branch_op_d = 3'd4; end
      6'h02: jump_d = 2'b10;
      6'h03: begin jump_d = 2'b11; reg_write_d = 1'b1; end
      default: ;
    endcase
  end

  logic ex_reg_write_q, ex_mem_to_reg_q, ex_mem_read_q, ex_mem_write_q;
  logic ex_branch_q, ex_reg_dst_q, ex_alu_src_q, ex_valid_q;
  logic [ALUOP_W-1:0] ex_alu_op_q;
  logic [1:0] ex_jump_q;
  logic [2:0] ex_branch_op_q;
  logic md_busy_q, md_done_q;

  // rt is only a source for R-type, beq, bne and sw; elsewhere it is the destination.
  logic rt_src, load_use, md_stall, stall_c, flush_c, issue;
  assign rt_src   = (bus.opcode == 6'h00) | (bus.opcode == 6'h04) |
                    (bus.opcode == 6'h05) | (bus.opcode == 6'h2B);
  assign load_use = bus.id_valid & ex_mem_read_q & (bus.ex_rt != 5'd0) &
                    ((bus.ex_rt == bus.rs) | ((bus.ex_rt == bus.rt) & rt_src));
`ifdef PIPE_CTRL_MULDIV_EN
  assign md_stall = bus.id_valid & md_busy_q & (md_op_d | md_rd_d);
`else
  assign md_stall = 1'b0;
`endif
  assign flush_c  = bus.branch_taken | (ex_valid_q & (ex_jump_q != 2'b00));
  assign stall_c  = (load_use | md_stall) & ~flush_c;
  assign issue    = bus.id_valid & ~flush_c & ~load_use & ~md_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_reg_write_q <= 1'b0; ex_mem_to_reg_q <= 1'b0; ex_mem_read_q <= 1'b0;
      ex_mem_write_q <= 1'b0; ex_branch_q <= 1'b0; ex_reg_dst_q <= 1'b0;
      ex_alu_src_q <= 1'b0; ex_alu_op_q <= '0; ex_jump_q <= 2'b00;
      ex_branch_op_q <= 3'd0; ex_valid_q <= 1'b0;
    end else if (issue) begin
      ex_reg_write_q <= reg_write_d; ex_mem_to_reg_q <= mem_to_reg_d; ex_mem_read_q <= mem_read_d;
      ex_mem_write_q <= mem_write_d; ex_branch_q <= branch_d; ex_reg_dst_q <= reg_dst_d;
      ex_alu_src_q <= alu_src_d; ex_alu_op_q <= ALUOP_W'(alu_op_d); ex_jump_q <= jump_d;
      ex_branch_op_q <= branch_op_d; ex_valid_q <= 1'b1;
    end else begin
      ex_reg_write_q <= 1'b0; ex_mem_to_reg_q <= 1'b0; ex_mem_read_q <= 1'b0;
      ex_mem_write_q <= 1'b0; ex_branch_q <= 1'b0; ex_reg_dst_q <= 1'b0;
      ex_alu_src_q <= 1'b0; ex_alu_op_q <= '0; ex_jump_q <= 2'b00;
      ex_branch_op_q <= 3'd0; ex_valid_q <= 1'b0;
    end
  end

`ifdef PIPE_CTRL_MULDIV_EN
  localparam int CW = $clog2(MD_LAT);
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
  md_state_e md_state_q;
  logic [CW-1:0] md_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_state_q <= MD_IDLE; md_cnt_q <= '0; md_busy_q <= 1'b0; md_done_q <= 1'b0;
    end else begin
      case (md_state_q)
        MD_IDLE: if (issue & md_op_d) begin
          md_state_q <= MD_BUSY; md_cnt_q <= CW'(MD_LAT - 1); md_busy_q <= 1'b1;
        end
        MD_BUSY: if (md_cnt_q == '0) begin
          md_state_q <= MD_DONE; md_done_q <= 1'b1;
        end else begin
          md_cnt_q <= md_cnt_q - 1'b1;
        end
        MD_DONE: begin
          md_state_q <= MD_IDLE; md_busy_q <= 1'b0; md_done_q <= 1'b0;
        end
        default: begin
          md_state_q <= MD_IDLE; md_busy_q <= 1'b0; md_done_q <= 1'b0;
        end
      endcase
    end
  end
`else
  assign md_busy_q = 1'b0;
  assign md_done_q = 1'b0;
`endif

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_c;
  assign bus.ex_reg_write  = ex_reg_write_q;
  assign bus.ex_mem_to_reg = ex_mem_to_reg_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_mem_write  = ex_mem_write_q;
  assign bus.ex_branch     = ex_branch_q;
  assign bus.ex_reg_dst    = ex_reg_dst_q;
  assign bus.ex_alu_src    = ex_alu_src_q;
  assign bus.ex_alu_op     = ex_alu_op_q;
  assign bus.ex_jump       = ex_jump_q;
  assign bus.ex_branch_op  = ex_branch_op_q;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.md_busy       = md_busy_q;
  assign bus.md_done       = md_done_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad   = 0;

  pipe_ctrl_unit_if #(.ALUOP_W(4)) bus ();
  pipe_ctrl_unit #(.ALUOP_W(4), .MD_LAT(4)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  logic [16:0] obs_bun;
  assign obs_bun = {bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_read, bus.ex_mem_write,
                    bus.ex_branch, bus.ex_reg_dst, bus.ex_alu_src, bus.ex_alu_op,
                    bus.ex_jump, bus.ex_branch_op, bus.ex_valid};

  function automatic logic [16:0] bun(input logic rw, m2r, mr, mw, br, rd, as,
                                      input logic [3:0] alu, input logic [1:0] jmp,
                                      input logic [2:0] bop, input logic v);
    return {rw, m2r, mr, mw, br, rd, as, alu, jmp, bop, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs_v, input logic [4:0] rt_v, input logic v);
    bus.opcode = op; bus.funct = fn; bus.rs = rs_v; bus.rt = rt_v; bus.id_valid = v;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic dec_chk(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [16:0] exp);
    set_id(op, fn, 5'd0, 5'd0, 1'b1);
    tick();
    chk(tag, obs_bun, exp);
  endtask

  localparam logic [16:0] BUBBLE = 17'h0;
  localparam logic [16:0] NOPV   = 17'h1;

  initial begin
    bus.ex_rt = 5'd0; bus.branch_taken = 1'b0;
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 1'b0);
    #1;
    chk("rst_bundle", obs_bun, BUBBLE);
    chk("rst_md_busy", bus.md_busy, 0);
    chk("rst_md_done", bus.md_done, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_flush", bus.flush, 0);
    #1 reset = 1'b0;

    set_id(6'h00, 6'h20, 5'd1, 5'd2, 1'b1);
    #1 chk("add_nostall", bus.stall, 0);
    tick();
    chk("add_issue", obs_bun, bun(1,0,0,0,0,0,0,4'h1,2'b00,3'd0,1));

    set_id(6'h23, 6'h00, 5'd1, 5'd5, 1'b1);
    tick();
    chk("lw_issue", obs_bun, bun(1,1,1,0,0,1,1,4'h1,2'b00,3'd0,1));
    bus.ex_rt = 5'd5;
    set_id(6'h00, 6'h20, 5'd5, 5'd2, 1'b1);
    #1 chk("lu_stall", bus.stall, 1);
    chk("lu_noflush", bus.flush, 0);
    tick();
    chk("lu_bubble", obs_bun, BUBBLE);
    chk("lu_stall_drop", bus.stall, 0);
    tick();
    chk("lu_add_issue", obs_bun, bun(1,0,0,0,0,0,0,4'h1,2'b00,3'd0,1));

    set_id(6'h23, 6'h00, 5'd1, 5'd0, 1'b1);
    bus.ex_rt = 5'd0;
    tick();
    set_id(6'h00, 6'h20, 5'd0, 5'd0, 1'b1);
    #1 chk("r0_nostall", bus.stall, 0);

    set_id(6'h23, 6'h00, 5'd1, 5'd7, 1'b1);
    tick();
    bus.ex_rt = 5'd7;
    set_id(6'h08, 6'h00, 5'd3, 5'd7, 1'b1);
    #1 chk("addi_rt_nostall", bus.stall, 0);
    set_id(6'h2B, 6'h00, 5'd3, 5'd7, 1'b1);
    #1 chk("sw_rt_stall", bus.stall, 1);
    set_id(6'h04, 6'h00, 5'd3, 5'd7, 1'b1);
    #1 chk("beq_rt_stall", bus.stall, 1);
    bus.branch_taken = 1'b1;
    #1 chk("bt_flush", bus.flush, 1);
    chk("bt_stall_masked", bus.stall, 0);
    tick();
    chk("bt_bubble", obs_bun, BUBBLE);
    bus.branch_taken = 1'b0;
    bus.ex_rt = 5'd0;

    dec_chk("addu", 6'h00, 6'h21, bun(1,0,0,0,0,0,0,4'hA,2'b00,3'd0,1));
    dec_chk("sub",  6'h00, 6'h22, bun(1,0,0,0,0,0,0,4'h2,2'b00,3'd0,1));
    dec_chk("subu", 6'h00, 6'h23, bun(1,0,0,0,0,0,0,4'hB,2'b00,3'd0,1));
    dec_chk("and",  6'h00, 6'h24, bun(1,0,0,0,0,0,0,4'h3,2'b00,3'd0,1));
    dec_chk("or",   6'h00, 6'h25, bun(1,0,0,0,0,0,0,4'h4,2'b00,3'd0,1));
    dec_chk("nor",  6'h00, 6'h27, bun(1,0,0,0,0,0,0,4'h5,2'b00,3'd0,1));
    dec_chk("slt",  6'h00, 6'h2A, bun(1,0,0,0,0,0,0,4'h6,2'b00,3'd0,1));
    dec_chk("sll",  6'h00, 6'h00, bun(1,0,0,0,0,0,0,4'h7,2'b00,3'd0,1));
    dec_chk("srl",  6'h00, 6'h02, bun(1,0,0,0,0,0,0,4'h8,2'b00,3'd0,1));
    dec_chk("sra",  6'h00, 6'h03, bun(1,0,0,0,0,0,0,4'h9,2'b00,3'd0,1));
    dec_chk("andi", 6'h0C, 6'h00, bun(1,0,0,0,0,1,1,4'h3,2'b00,3'd0,1));
    dec_chk("ori",  6'h0D, 6'h00, bun(1,0,0,0,0,1,1,4'h4,2'b00,3'd0,1));
    dec_chk("slti", 6'h0A, 6'h00, bun(1,0,0,0,0,1,1,4'h6,2'b00,3'd0,1));
    dec_chk("addi", 6'h08, 6'h00, bun(1,0,0,0,0,1,1,4'h1,2'b00,3'd0,1));
    dec_chk("addiu",6'h09, 6'h00, bun(1,0,0,0,0,1,1,4'hA,2'b00,3'd0,1));
    dec_chk("lui",  6'h0F, 6'h00, bun(1,0,0,0,0,1,1,4'hF,2'b00,3'd0,1));
    dec_chk("sw",   6'h2B, 6'h00, bun(0,0,0,1,0,0,1,4'h1,2'b00,3'd0,1));
    dec_chk("beq",  6'h04, 6'h00, bun(0,0,0,0,1,0,0,4'h0,2'b00,3'd1,1));
    dec_chk("bne",  6'h05, 6'h00, bun(0,0,0,0,1,0,0,4'h0,2'b00,3'd2,1));
    dec_chk("bgtz", 6'h07, 6'h00, bun(0,0,0,0,1,0,0,4'h0,2'b00,3'd3,1));
    dec_chk("regimm",6'h01,6'h00, bun(0,0,0,0,1,0,0,4'h0,2'b00,3'd4,1));
    dec_chk("undef_op", 6'h3F, 6'h00, NOPV);
    dec_chk("undef_fn", 6'h00, 6'h3F, NOPV);
    chk("branch_in_ex_noflush", bus.flush, 0);

    dec_chk("jal", 6'h03, 6'h00, bun(1,0,0,0,0,0,0,4'h0,2'b11,3'd0,1));
    chk("jal_flush", bus.flush, 1);
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 1'b1);
    tick();
    chk("jal_bubble", obs_bun, BUBBLE);
    chk("jal_flush_drop", bus.flush, 0);
    dec_chk("j", 6'h02, 6'h00, bun(0,0,0,0,0,0,0,4'h0,2'b10,3'd0,1));
    chk("j_flush", bus.flush, 1);
    tick();
    chk("j_bubble", obs_bun, BUBBLE);
    dec_chk("jr", 6'h00, 6'h08, bun(0,0,0,0,0,0,0,4'h0,2'b01,3'd0,1));
    chk("jr_flush", bus.flush, 1);
    tick();
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 1'b0);
    tick();
    chk("idle_bubble", obs_bun, BUBBLE);

    dec_chk("pre_rst_add", 6'h00, 6'h20, bun(1,0,0,0,0,0,0,4'h1,2'b00,3'd0,1));
    #2 reset = 1'b1;
    #1 chk("async_rst_bundle", obs_bun, BUBBLE);
    @(negedge clock) reset = 1'b0;

`ifdef PIPE_CTRL_MULDIV_EN
    dec_chk("mult", 6'h00, 6'h18, NOPV);
    chk("mult_busy", bus.md_busy, 1);
    set_id(6'h00, 6'h12, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("mflo_stall", bus.stall, 1);
      tick();
      chk("md_done_early", bus.md_done, 0);
      chk("md_busy_mid", bus.md_busy, 1);
    end
    tick();
    chk("md_done_pulse", bus.md_done, 1);
    chk("md_busy_done", bus.md_busy, 1);
    chk("mflo_stall_done", bus.stall, 1);
    tick();
    chk("md_done_drop", bus.md_done, 0);
    chk("md_busy_drop", bus.md_busy, 0);
    chk("mflo_stall_drop", bus.stall, 0);
    chk("mflo_not_yet", obs_bun, BUBBLE);
    tick();
    chk("mflo_issue", obs_bun, bun(1,0,0,0,0,0,0,4'hD,2'b00,3'd0,1));
    dec_chk("mfhi", 6'h00, 6'h10, bun(1,0,0,0,0,0,0,4'hC,2'b00,3'd0,1));

    set_id(6'h00, 6'h19, 5'd0, 5'd0, 1'b1);
    bus.branch_taken = 1'b1;
    tick();
    bus.branch_taken = 1'b0;
    chk("flushed_md_idle", bus.md_busy, 0);

    dec_chk("divu", 6'h00, 6'h1B, NOPV);
    set_id(6'h00, 6'h20, 5'd0, 5'd0, 1'b0);
    tick();
    chk("div_busy", bus.md_busy, 1);
    #2 reset = 1'b1;
    #1 chk("md_rst_busy", bus.md_busy, 0);
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("md_rst_no_done", bus.md_done, 0);
    end
`else
    dec_chk("mult_undef", 6'h00, 6'h18, NOPV);
    chk("mult_undef_busy", bus.md_busy, 0);
    set_id(6'h00, 6'h12, 5'd0, 5'd0, 1'b1);
    #1 chk("mflo_undef_nostall", bus.stall, 0);
    tick();
    chk("mflo_undef", obs_bun, NOPV);
    chk("md_done_tied", bus.md_done, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter ALUOP_W, default 4, ALU-op field width; SHALL be >= 4, codes zero-extended.
REQ-002 Parameter MD_LAT, default 32, multiply/divide latency in cycles; SHALL be >= 2.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 opcode  in  6, funct  in  6, rs  in  5, rt  in  5: ID-stage instruction fields.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 ex_rt  in  5  destination register of the instruction currently in EX.
REQ-008 branch_taken  in  1  EX-stage branch resolved taken.
REQ-009 stall  out  1  hold PC and IF/ID; flush  out  1  squash IF/ID.
REQ-010 ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_reg_dst, ex_alu_src  out  1 each: registered EX control.
REQ-011 ex_alu_op  out  ALUOP_W; ex_jump  out  2 (00 none, 01 jr, 10 j, 11 jal); ex_branch_op  out  3; ex_valid  out  1.
REQ-012 md_busy  out  1; md_done  out  1, single-cycle pulse.

Function
REQ-013 R-type (opcode 00) funct->alu_op, reg_write=1: 20->1, 21->A, 22->2, 23->B, 24->3, 25->4, 27->5, 2A->6, 00->7, 02->8, 03->9 (hex).
REQ-014 I-type, reg_write=alu_src=reg_dst=1: 0C->3, 0D->4, 0A->6, 08->1, 09->A, 0F->F; 23 (lw) alu_op 1 plus mem_read, mem_to_reg; 2B (sw) alu_op 1, alu_src, mem_write only.
REQ-015 Branches, branch=1: 04->branch_op 1, 05->2, 07->3, 01->4.
REQ-016 Jumps: R-type funct 08 -> jump 01; opcode 02 -> 10; opcode 03 -> 11, reg_write=1.
REQ-017 Any undefined encoding SHALL decode to an all-zero bundle with ex_valid=1.
REQ-018 ID/EX register loads on each rising edge: all-zero bundle and ex_valid=0 if flush, stall or !id_valid; else decoded bundle and ex_valid=1. Latency: one cycle.
REQ-019 Load-use: stall=1 combinationally when id_valid & ex_mem_read & ex_rt!=0 & (ex_rt==rs | (ex_rt==rt & ID is R-type, beq, bne or sw)).
REQ-020 flush=1 combinationally when branch_taken | (ex_valid & ex_jump!=00).
REQ-021 flush SHALL dominate stall: when both true, stall=0 and a bubble is loaded.
REQ-022 Register 0 as destination SHALL never cause a stall.

Reset
REQ-023 On reset assertion, immediately: all ex_* outputs 0, ex_valid=0, md_busy=0, md_done=0, FSM IDLE, counter 0; stall and flush follow inputs.
REQ-024 Reset mid-multiply SHALL abandon the operation; no md_done pulse on release.

Configuration
REQ-025 Macro PIPE_CTRL_MULDIV_EN compiles in the multiply/divide sequencer.
REQ-026 Defined: funct 18/19/1A/1B (mult, multu, div, divu) decode all-zero except ex_valid; funct 10 (mfhi) alu_op C, 12 (mflo) alu_op D, reg_write=1.
REQ-027 Defined: FSM IDLE->BUSY when an md op loads into EX (counter=MD_LAT-1); BUSY decrements each cycle; at 0 -> DONE (md_done=1 one cycle) -> IDLE; md_busy=1 in BUSY and DONE.
REQ-028 Defined: stall=1 while md_busy and ID holds an md op, mfhi or mflo; a flushed md op SHALL NOT start the FSM.
REQ-029 Undefined: those functs follow REQ-017; md_busy and md_done tied 0.

Verification
REQ-030 lw (23) with ex_rt=5, then ID add rs=5 -> stall=1 one cycle, bubble ex_valid=0, add issues next cycle.
REQ-031 ex_rt=0 after lw, ID rs=0 -> stall=0.
REQ-032 branch_taken=1 coincident with load-use hazard -> flush=1, stall=0, bubble loaded.
REQ-033 jal in ID -> next cycle ex_jump=11, ex_reg_write=1, flush=1.
REQ-034 MULDIV_EN, MD_LAT=4: mult then mflo -> mflo stalled; md_done pulses 4 cycles after mult enters EX; mflo issues the cycle after DONE.
REQ-035 Reset asserted in BUSY -> md_busy=0 immediately, no md_done after release.
